// File: rtl/modulo_escalonador_transferencia_rolhas_pkg.sv
// modulo_escalonador_transferencia_rolhas_pkg: shared widths, default limits and state encodings for the cork transfer scheduler
// No ports; imported by the scheduler, its lot calculator and its interface.
package modulo_escalonador_transferencia_rolhas_pkg;
    localparam int WIDTH         = 7;
    localparam int DEF_CAP       = 99;
    localparam int DEF_MIN_LEVEL = 5;
    localparam int DEF_AUTO_LOT  = 15;
    localparam int DEF_OP_LOT    = 20;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CALC   = 2'b01,
        TRANSF = 2'b10,
        FIM    = 2'b11
    } estado_t;
endpackage

// File: rtl/modulo_escalonador_transferencia_rolhas_if.sv
// modulo_escalonador_transferencia_rolhas_if: request and status bundle between the scheduler and the reservoir/operator logic
// master drives auto_en, op_req, buf_prim, buf_sec; slave (scheduler) drives step, grant_auto, grant_op, busy, done, abort, lot, estado.
interface modulo_escalonador_transferencia_rolhas_if;
    import modulo_escalonador_transferencia_rolhas_pkg::*;
    logic             auto_en;
    logic             op_req;
    logic [WIDTH-1:0] buf_prim;
    logic [WIDTH-1:0] buf_sec;
    logic             step;
    logic             grant_auto;
    logic             grant_op;
    logic             busy;
    logic             done;
    logic             abort;
    logic [WIDTH-1:0] lot;
    logic [1:0]       estado;
    modport master (
        output auto_en, op_req, buf_prim, buf_sec,
        input  step, grant_auto, grant_op, busy, done, abort, lot, estado
    );
    modport slave (
        input  auto_en, op_req, buf_prim, buf_sec,
        output step, grant_auto, grant_op, busy, done, abort, lot, estado
    );
endinterface

// File: rtl/modulo_calc_lote_rolhas.sv
// modulo_calc_lote_rolhas: lot size = min(lot_max, CAP - buf_prim saturated at 0, buf_sec)
// Ports: buf_prim, buf_sec (current counts), lot_max (per-grant limit) in; lote (transferable corks) out.
module modulo_calc_lote_rolhas
    import modulo_escalonador_transferencia_rolhas_pkg::*;
#(
    parameter int CAP = DEF_CAP
)(
    input  logic [WIDTH-1:0] buf_prim,
    input  logic [WIDTH-1:0] buf_sec,
    input  logic [WIDTH-1:0] lot_max,
    output logic [WIDTH-1:0] lote
);
    logic [WIDTH-1:0] room;
    logic [WIDTH-1:0] m;
    assign room = (buf_prim >= WIDTH'(CAP)) ? '0 : WIDTH'(CAP) - buf_prim;
    assign m    = (lot_max < room) ? lot_max : room;
    assign lote = (m < buf_sec) ? m : buf_sec;
endmodule

// File: rtl/modulo_escalonador_transferencia_rolhas.sv
// modulo_escalonador_transferencia_rolhas: arbitrates auto refill vs operator load and emits one step per cork moved
// Ports: clk, Nclr (async active-low reset); bus (slave): auto_en, op_req, buf_prim, buf_sec in;
// step, grant_auto, grant_op, busy, done, abort, lot, estado out.
module modulo_escalonador_transferencia_rolhas
    import modulo_escalonador_transferencia_rolhas_pkg::*;
#(
    parameter int CAP       = DEF_CAP,
    parameter int MIN_LEVEL = DEF_MIN_LEVEL,
    parameter int AUTO_LOT  = DEF_AUTO_LOT,
    parameter int OP_LOT    = DEF_OP_LOT
)(
    input  logic                                    clk,
    input  logic                                    Nclr,
    modulo_escalonador_transferencia_rolhas_if.slave bus
);
    estado_t          state, state_nx;
    logic             op_pend, grant_auto, grant_op, abort_f;
    logic             areq, cut, step;
    logic [WIDTH-1:0] rem, lot, lot_calc, lot_max;
    assign areq    = bus.auto_en && (bus.buf_prim < WIDTH'(MIN_LEVEL));
    // an auto lot is cut the moment production stops; operator lots run to completion
    assign cut     = grant_auto && !bus.auto_en;
    assign lot_max = grant_auto ? WIDTH'(AUTO_LOT) : WIDTH'(OP_LOT);
    modulo_calc_lote_rolhas #(.CAP(CAP)) u_calc (
        .buf_prim (bus.buf_prim),
        .buf_sec  (bus.buf_sec),
        .lot_max  (lot_max),
        .lote     (lot_calc)
    );
    always_comb begin
        state_nx = state;
        step     = 1'b0;
        case (state)
            IDLE:   state_nx = (areq || op_pend) ? CALC : IDLE;
            CALC:   state_nx = (lot_calc == '0) ? FIM : TRANSF;
            TRANSF: begin
                step     = !cut;
                state_nx = (cut || rem == WIDTH'(1)) ? FIM : TRANSF;
            end
            FIM:    state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge Nclr) begin
        if (!Nclr) begin
            state      <= IDLE;
            op_pend    <= 1'b0;
            grant_auto <= 1'b0;
            grant_op   <= 1'b0;
            abort_f    <= 1'b0;
            rem        <= '0;
            lot        <= '0;
        end else begin
            state   <= state_nx;
            // granting clears the pending request; a pulse arriving at that moment is absorbed
            op_pend <= (state == IDLE && !areq && op_pend) ? 1'b0 : (op_pend || bus.op_req);
            if (state == IDLE) begin
                grant_auto <= areq;
                grant_op   <= !areq && op_pend;
            end
            if (state == CALC) begin
                lot <= lot_calc;
                rem <= lot_calc;
            end
            if (state == TRANSF) begin
                rem     <= rem - WIDTH'(1);
                abort_f <= cut;
            end
            if (state == FIM) begin
                grant_auto <= 1'b0;
                grant_op   <= 1'b0;
                abort_f    <= 1'b0;
                rem        <= '0;
            end
        end
    end
    assign bus.step       = step;
    assign bus.grant_auto = grant_auto;
    assign bus.grant_op   = grant_op;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == FIM);
    assign bus.abort      = (state == FIM) && abort_f;
    assign bus.lot        = lot;
    assign bus.estado     = state;
endmodule

// File: tb/tb_modulo_escalonador_transferencia_rolhas.sv
// tb_modulo_escalonador_transferencia_rolhas: self-checking bench for the cork transfer scheduler
module tb_modulo_escalonador_transferencia_rolhas;
    logic clk = 1'b0;
    logic Nclr = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   prim, sec;

    modulo_escalonador_transferencia_rolhas_if bus();

    modulo_escalonador_transferencia_rolhas dut (
        .clk  (clk),
        .Nclr (Nclr),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int prim;
        int sec;
        bit op;
        int lot;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_bufs(input int p, input int s);
        prim = p;
        sec = s;
        bus.buf_prim = 7'(p);
        bus.buf_sec = 7'(s);
    endtask

    function automatic int ref_lot(input int p, input int s, input bit op);
        int room, l;
        room = (p >= 99) ? 0 : 99 - p;
        l = op ? 20 : 15;
        if (room < l) l = room;
        if (s < l) l = s;
        return l;
    endfunction

    task automatic watch(input string nm, input int exp_lot, input bit op, input int lat,
                         input int drop, input int op_edges);
        int t, n, el, steps, exp_steps, lt;
        bit stopped, gap, dn, ab;
        t = 0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
            n++;
            if (t >= op_edges) bus.op_req = 1'b0;
        end while (!bus.busy && n < 20);
        chk({nm, " latency"}, n, lat);
        chk({nm, " grant"}, int'({bus.grant_op, bus.grant_auto}), op ? 2 : 1);
        steps = 0; el = 0; stopped = 0; gap = 0; dn = 0; ab = 0; lt = 0;
        while (!dn && el < 80) begin
            @(posedge clk);
            #1;
            t++;
            el++;
            if (t >= op_edges) bus.op_req = 1'b0;
            if (drop > 0 && steps == drop) bus.auto_en = 1'b0;
            #1;
            if (bus.step) begin
                if (stopped) gap = 1;
                steps++;
                set_bufs(prim + 1, sec - 1);
            end else if (steps > 0) stopped = 1;
            if (bus.done) begin
                dn = 1;
                ab = bus.abort;
                lt = int'(bus.lot);
            end
        end
        bus.auto_en = 1'b0;
        exp_steps = (drop > 0) ? drop : exp_lot;
        chk({nm, " done"}, int'(dn), 1);
        chk({nm, " steps"}, steps, exp_steps);
        chk({nm, " gap"}, int'(gap), 0);
        chk({nm, " abort"}, int'(ab), (drop > 0) ? 1 : 0);
        chk({nm, " lot"}, lt, exp_lot);
        chk({nm, " cycles"}, el, exp_steps + 1 + ((drop > 0) ? 1 : 0));
    endtask

    task automatic idle_check(input string nm, input int cycles);
        int b;
        b = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (bus.busy || bus.step) b++;
        end
        chk({nm, " idle"}, b, 0);
    endtask

    initial begin
        int steps, n, p, s;
        bit op;
        vecs[0] = '{3, 40, 0, 15};
        vecs[1] = '{90, 50, 1, 9};
        vecs[2] = '{99, 50, 1, 0};
        vecs[3] = '{10, 7, 1, 7};
        vecs[4] = '{0, 3, 0, 3};
        vecs[5] = '{4, 0, 0, 0};
        vecs[6] = '{60, 100, 1, 20};
        vecs[7] = '{120, 30, 1, 0};
        vecs[8] = '{80, 40, 1, 19};
        vecs[9] = '{2, 127, 0, 15};

        bus.auto_en = 1'b0;
        bus.op_req = 1'b0;
        set_bufs(50, 50);
        #12;
        chk("reset step", int'(bus.step), 0);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset done", int'(bus.done), 0);
        chk("reset grants", int'({bus.grant_auto, bus.grant_op, bus.abort}), 0);
        chk("reset lot", int'(bus.lot), 0);
        chk("reset estado", int'(bus.estado), 0);
        @(negedge clk);
        Nclr = 1'b1;
        idle_check("post reset", 3);

        foreach (vecs[i]) begin
            set_bufs(vecs[i].prim, vecs[i].sec);
            if (vecs[i].op) begin
                bus.op_req = 1'b1;
                watch($sformatf("vec%0d", i), vecs[i].lot, 1'b1, 2, 0, 1);
            end else begin
                bus.auto_en = 1'b1;
                watch($sformatf("vec%0d", i), vecs[i].lot, 1'b0, 1, 0, 0);
            end
            idle_check($sformatf("vec%0d", i), 2);
        end

        // auto and operator in the same cycle, second op pulse while pending is absorbed
        set_bufs(2, 100);
        bus.auto_en = 1'b1;
        bus.op_req = 1'b1;
        watch("simul auto", 15, 1'b0, 1, 0, 2);
        watch("simul op", 20, 1'b1, 2, 0, 0);
        idle_check("simul", 6);

        // production stops after 4 steps of an auto lot
        set_bufs(3, 100);
        bus.auto_en = 1'b1;
        watch("abort", 15, 1'b0, 1, 4, 0);
        idle_check("abort", 2);

        // reset mid operator lot with another operator request pending
        set_bufs(10, 100);
        bus.op_req = 1'b1;
        @(posedge clk);
        #1;
        bus.op_req = 1'b0;
        steps = 0;
        n = 0;
        while (steps < 5 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.step) steps++;
            bus.op_req = (steps == 2);
        end
        chk("midreset steps", steps, 5);
        bus.op_req = 1'b0;
        #2;
        Nclr = 1'b0;
        #1;
        chk("midreset step", int'(bus.step), 0);
        chk("midreset busy", int'(bus.busy), 0);
        chk("midreset estado", int'(bus.estado), 0);
        chk("midreset grant", int'(bus.grant_op), 0);
        chk("midreset lot", int'(bus.lot), 0);
        repeat (2) @(negedge clk);
        Nclr = 1'b1;
        idle_check("midreset", 10);

        for (int k = 0; k < 30; k++) begin
            op = $urandom_range(0, 1) == 1;
            p = op ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 4));
            s = $urandom_range(0, 127);
            set_bufs(p, s);
            if (op) begin
                bus.op_req = 1'b1;
                watch($sformatf("rnd%0d", k), ref_lot(p, s, 1'b1), 1'b1, 2, 0, 1);
            end else begin
                bus.auto_en = 1'b1;
                watch($sformatf("rnd%0d", k), ref_lot(p, s, 1'b0), 1'b0, 1, 0, 0);
            end
            idle_check($sformatf("rnd%0d", k), 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/modulo_escalonador_transferencia_rolhas.md
Name: modulo_escalonador_transferencia_rolhas

Overview:
- Sequences cork transfers from the secondary cork buffer into the primary cork reservoir.
- Arbitrates between two requesters:
  - automatic refill, when the reservoir is below its minimum during production;
  - the operator manual-load request.
- For each granted lot, emits one step pulse per cork. The external up/down counters consume `step`: primary +1, secondary −1.
- Sits between the operator debounce logic, the reservoir/secondary counters and the filling MEF.

Parameters:
- WIDTH, 7, width of all cork counts.
- CAP, 99, reservoir capacity (display limit).
- MIN_LEVEL, 5, auto refill requested when primary < MIN_LEVEL.
- AUTO_LOT, 15, corks moved per automatic grant.
- OP_LOT, 20, corks moved per operator grant.

Ports:
- clk, in, 1, system clock (divided clock domain).
- Nclr, in, 1, reset; asynchronous, active-low.
- auto_en, in, 1, production running (start_stop); enables automatic requests.
- op_req, in, 1, operator request; single-cycle pulse, already debounced.
- buf_prim, in, WIDTH, current primary reservoir count.
- buf_sec, in, WIDTH, current secondary buffer count.
- step, out, 1, one cork transferred this cycle.
- grant_auto, out, 1, automatic lot in progress.
- grant_op, out, 1, operator lot in progress.
- busy, out, 1, state != IDLE.
- done, out, 1, one-cycle pulse at the end of a lot.
- abort, out, 1, one-cycle pulse together with done when an auto lot is cut short by auto_en=0.
- lot, out, WIDTH, latched size of the current lot.
- estado, out, 2, state encoding for debug.

Behaviour:
- Reset (Nclr=0, asynchronous):
  - state = IDLE;
  - op_pend = 0, rem = 0, lot = 0;
  - all outputs 0.
  - The same applies when reset is asserted mid-lot: the lot is abandoned and no further step is issued.
- op_pend:
  - set by op_req = 1 in any state;
  - cleared in the cycle the operator is granted;
  - a second op_req while already pending is absorbed (not queued twice).
- Automatic request: areq = auto_en AND (buf_prim < MIN_LEVEL), evaluated combinationally in IDLE.
- States and encodings: IDLE = 00, CALC = 01, TRANSF = 10, FIM = 11.
- IDLE:
  - If areq: grant_auto ← 1 and go to CALC.
  - Else if op_pend: grant_op ← 1, clear op_pend and go to CALC.
  - Fixed priority: auto over operator. If both are present in the same cycle, the operator stays pending and is served next.
- CALC (one cycle):
  - lot ← min(L, CAP − buf_prim, buf_sec), with L = AUTO_LOT or OP_LOT per grant; rem ← the same value.
  - If buf_prim ≥ CAP, CAP − buf_prim is taken as 0 (no underflow).
  - If lot = 0 → FIM; else → TRANSF.
- TRANSF:
  - step = 1 every cycle; rem decrements each cycle.
  - When rem = 1 → FIM. Exactly `lot` consecutive step cycles.
  - If grant_auto AND auto_en = 0: step = 0 that cycle and go to FIM with abort flagged. Operator lots ignore auto_en.
- FIM (one cycle):
  - done = 1; abort = 1 if flagged;
  - clear grant_* and rem; lot is held until the next CALC.
  - → IDLE.
- Latency:
  - op_req at cycle n → grant at n+1 (IDLE sees op_pend) → CALC at n+1 → first step at n+2 → done at n+2+lot.
  - An auto request seen in IDLE at cycle n: CALC at n, first step at n+1.
- The block never reads buf_prim/buf_sec during TRANSF; all limits are fixed at CALC. This guarantees the reservoir never exceeds CAP and the secondary never goes below 0.
- Arithmetic: all counts unsigned WIDTH bits; comparisons unsigned.

Decomposition:
- Shared package (pkg_rolhas):
  - state encodings;
  - CAP, MIN_LEVEL, AUTO_LOT, OP_LOT defaults;
  - WIDTH.
- One natural sub-module: modulo_calc_lote_rolhas.
  - Purely combinational 3-way min with saturating CAP − buf_prim.
  - Instantiated once, feeding CALC.
- The remaining-count register reuses the existing 7-bit down-counter style.

Test Plan:
- Auto refill: auto_en=1, buf_prim=3, buf_sec=40 → grant_auto, lot=15, exactly 15 consecutive step cycles, then done=1, abort=0.
- Capacity clamp: op_req pulse, buf_prim=90, buf_sec=50 → grant_op, lot=9, 9 steps, done; buf_prim=99 → lot=0, no step, done next cycle.
- Secondary shortage: op_req, buf_prim=10, buf_sec=7 → lot=7, 7 steps.
- Simultaneous requests: op_req and areq (buf_prim=2) in the same cycle → auto lot of 15 first; then the operator lot of 20 starts with no new op_req.
- Abort: auto lot running, drop auto_en after 4 steps → step stops immediately, done=1 and abort=1 in the same cycle, lot still reads 15.
- Reset mid-lot: Nclr low during an operator lot after 5 steps → outputs 0 asynchronously, estado=00, op_pend cleared; after release no step until a new request.
